// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and oversampling ratio.
// Imported by both the transmitter and the receiver.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // Starting value of the running XOR so that the final value is the bit to send.
  function automatic logic parity_seed(input int parity);
    return (parity == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake of the UART transmitter: request/data in, busy/done out.
// The master modport belongs to the TX FIFO / host logic.
interface uart_tx_if;
  import uart_pkg::*;

  logic       tx_start;
  logic [7:0] din;
  logic       tx_busy;
  logic       tx_done_tick;

  modport master (
    output tx_start,
    output din,
    input  tx_busy,
    input  tx_done_tick
  );

  modport slave (
    input  tx_start,
    input  din,
    output tx_busy,
    output tx_done_tick
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB-first, optional parity, stop bit(s),
// timed by the shared 16x oversampling enable s_tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = PAR_NONE
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     s_tick,
  uart_tx_if.slave host,
  output logic     tx
);

  localparam logic [4:0] TK_LAST    = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST  = 5'(SB_TICK - 1);
  localparam logic [2:0] BT_LAST    = 3'(DBIT - 1);
  localparam logic       PAR_INIT   = parity_seed(PARITY);
  localparam bit         HAS_PARITY = (PARITY != PAR_NONE);

  uart_state_t state_q, state_d;
  logic [4:0]  tk_q, tk_d;
  logic [2:0]  bt_q, bt_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tk_q    <= '0;
      bt_q    <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tk_q    <= tk_d;
      bt_q    <= bt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tk_d    = tk_q;
    bt_d    = bt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (host.tx_start) begin
          sh_d    = host.din;
          tk_d    = '0;
          par_d   = PAR_INIT;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (tk_q == TK_LAST) begin
            tk_d    = '0;
            bt_d    = '0;
            state_d = ST_DATA;
          end else begin
            tk_d = tk_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (tk_q == TK_LAST) begin
            tk_d  = '0;
            sh_d  = sh_q >> 1;
            par_d = par_q ^ sh_q[0];
            if (bt_q == BT_LAST) begin
              state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
            end else begin
              bt_d = bt_q + 3'd1;
            end
          end else begin
            tk_d = tk_q + 5'd1;
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (tk_q == TK_LAST) begin
            tk_d    = '0;
            state_d = ST_STOP;
          end else begin
            tk_d = tk_q + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (tk_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tk_d = tk_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the state being entered, so tx drops on the accepting edge.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = sh_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx                = tx_q;
  assign host.tx_busy      = (state_q != ST_IDLE);
  assign host.tx_done_tick = done;

endmodule
